// File: rtl/wb_console.sv
// wb_console: Wishbone slave feeding a byte-wide TX FIFO, with a status register and registered termination.
//   Parameters: DATA_WIDTH (bus width, multiple of 32), ADDR_WIDTH (byte address width),
//               FIFO_DEPTH (TX entries, power of 2, 2..128).
//   Ports: clk, rst (sync active-high); Wishbone slave adr_i/dat_i/dat_o/we_i/sel_i/stb_i/cyc_i,
//          ack_o/err_o/rty_o; byte stream tx_data_o/tx_valid_o/tx_ready_i.
//   Macro WB_CONSOLE_RTY_EN: a TXDATA push to a full FIFO terminates with rty_o instead of stalling.
module wb_console #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  input  logic                    stb_i,
  input  logic                    cyc_i,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    rty_o,
  output logic [7:0]              tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef WB_CONSOLE_RTY_EN
  localparam bit RTY = 1'b1;
`else
  localparam bit RTY = 1'b0;
`endif
  logic [7:0]            mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q;
  logic                  pend_q;
  logic [7:0]            pend_dat_q;
  logic                  ack_q, err_q, rty_q;
  logic [DATA_WIDTH-1:0] dat_q, status;
  logic                  full, accept, bad, tx_wr, pop, pend_go, push;
  logic [7:0]            push_dat;
  logic                  unused;
  assign unused = ^{sel_i[DATA_WIDTH/8-1:1], dat_i[DATA_WIDTH-1:8], adr_i[3:0]};
  assign full = count_q == CW'(FIFO_DEPTH);
  // A new request is only taken while no termination is on the bus and no stalled write is parked.
  assign accept = cyc_i & stb_i & ~(ack_q | err_q | rty_q) & ~pend_q;
  assign bad = |adr_i[ADDR_WIDTH-1:5];
  assign tx_wr = accept & ~bad & ~adr_i[4] & we_i & sel_i[0];
  assign pop = (count_q != '0) & tx_ready_i;
  // A parked write completes once the registered count shows room; dropping cyc_i abandons it.
  assign pend_go = pend_q & cyc_i & ~full;
  assign push = (tx_wr & ~full) | pend_go;
  assign push_dat = pend_q ? pend_dat_q : dat_i[7:0];
  assign status = DATA_WIDTH'({full, count_q == '0, 8'(count_q)});
  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;
  assign rty_o = rty_q;
  assign tx_valid_o = count_q != '0;
  assign tx_data_o = mem_q[rptr_q];
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= push_dat;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      pend_dat_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rty_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      ack_q      <= (accept & ~bad & ~(tx_wr & full)) | pend_go;
      err_q      <= accept & bad;
      rty_q      <= RTY & tx_wr & full;
      pend_q     <= ~RTY & ((pend_q & cyc_i & full) | (tx_wr & full));
      pend_dat_q <= (tx_wr & full) ? dat_i[7:0] : pend_dat_q;
      dat_q      <= (accept & ~bad & adr_i[4] & ~we_i) ? status : '0;
      wptr_q     <= push ? wptr_q + 1'b1 : wptr_q;
      rptr_q     <= pop ? rptr_q + 1'b1 : rptr_q;
      count_q    <= count_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: doc/wb_console.md
WB_CONSOLE -- requirements
Module: wb_console

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, Wishbone data width in bits (multiple of 32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, Wishbone byte-address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, TX FIFO entries (power of 2, 2..128).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 adr_i  input  ADDR_WIDTH  byte address.
REQ-008 dat_i  input  DATA_WIDTH  write data.
REQ-009 dat_o  output  DATA_WIDTH  read data.
REQ-010 we_i  input  1  write enable.
REQ-011 sel_i  input  DATA_WIDTH/8  byte-lane selects.
REQ-012 stb_i, cyc_i  input  1 each  Wishbone strobe and cycle.
REQ-013 ack_o, err_o, rty_o  output  1 each  transfer termination.
REQ-014 tx_data_o  output  8  FIFO head byte.
REQ-015 tx_valid_o  output  1  FIFO non-empty; tx_ready_i  input  1  consumer accepts byte.

Function
REQ-016 Request SHALL be accepted when cyc_i&stb_i are high and no termination is asserted that cycle.
REQ-017 Exactly one of ack_o/err_o/rty_o SHALL be asserted, for exactly one cycle, per accepted request; nominal latency is one cycle.
REQ-018 adr_i[ADDR_WIDTH-1:5] nonzero SHALL terminate with err_o, no state change, dat_o=0.
REQ-019 adr_i[4]=0 selects TXDATA; adr_i[4]=1 selects STATUS; adr_i[3:0] ignored.
REQ-020 TXDATA write with sel_i[0]=1 SHALL push dat_i[7:0]; with sel_i[0]=0 SHALL ack without push.
REQ-021 TXDATA read SHALL return 0; STATUS write SHALL ack and be ignored.
REQ-022 STATUS read SHALL return count in bits [7:0], empty bit 8, full bit 9, zeros elsewhere, sampled at acceptance.
REQ-023 dat_o SHALL be valid only while ack_o is high and 0 otherwise.
REQ-024 tx_valid_o = count!=0; tx_data_o = head byte; pop occurs when tx_valid_o&tx_ready_i.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; full decision uses count before the same-cycle pop.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-027 Push to full FIFO SHALL follow REQ-032/REQ-033; FIFO contents are never overwritten.
REQ-028 If cyc_i drops while a request is pending, the request SHALL be abandoned without push or termination.

Reset
REQ-029 On rst: pointers and count=0, ack_o=err_o=rty_o=0, dat_o=0, tx_valid_o=0, pending request discarded.
REQ-030 Reset asserted mid-transfer SHALL suppress that transfer's termination.
REQ-031 FIFO storage contents need not be reset.

Configuration
REQ-032 With WB_CONSOLE_RTY_EN defined: write to TXDATA with sel_i[0]=1 while full SHALL terminate with rty_o after one cycle, no push.
REQ-033 Without WB_CONSOLE_RTY_EN: such a write SHALL stall; ack_o and push occur in the cycle after count drops below FIFO_DEPTH; rty_o tied 0.

Verification
REQ-034 Write 0x41 to adr 0x0000, sel=0x0001 -> ack_o next cycle; tx_valid_o=1, tx_data_o=0x41.
REQ-035 Read adr 0x0010 after 3 pushes, tx_ready_i=0 -> dat_o=0x103? no: dat_o[7:0]=3, bit8=0, bit9=0, ack_o one cycle.
REQ-036 Access adr 0x0020 -> err_o one cycle, ack_o=0, count unchanged.
REQ-037 Fill 16 entries, tx_ready_i=0, write 0x5A: RTY_EN -> rty_o, count=16; no RTY_EN -> no ack until tx_ready_i pulsed, then ack, tail=0x5A.
REQ-038 Push 0x10..0x1F, tx_ready_i=1 continuous with concurrent writes -> output order preserved across pointer wrap, count never exceeds 16.
REQ-039 Assert rst during stalled write -> no termination, count=0, tx_valid_o=0 next cycle.
